// File: rtl/edge_pack_writer.sv
// Binarizes Sobel magnitudes and packs PACK pixels per memory word, with
// per-lane byte enables for partial words and an end-of-frame flush.
module edge_pack_writer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int PACK       = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           start_i,
    input  logic [DATA_WIDTH-1:0]          threshold_i,
    input  logic                           pixel_valid_i,
    input  logic [DATA_WIDTH-1:0]          pixel_i,
    input  logic [ADDR_WIDTH-1:0]          pixel_addr_i,
    input  logic                           src_finish_i,
    output logic                           mem_wr_en_o,
    output logic [ADDR_WIDTH-$clog2(PACK)-1:0] mem_addr_o,
    output logic [PACK*DATA_WIDTH-1:0]     mem_data_o,
    output logic [PACK-1:0]                mem_be_o,
    output logic [ADDR_WIDTH:0]            edge_cnt_o,
    output logic                           done_o
);
    localparam int LW  = $clog2(PACK);
    localparam int WAW = ADDR_WIDTH - LW;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   thr_q, thr_d;
    logic [PACK*DATA_WIDTH-1:0] buf_q, buf_d;
    logic [PACK-1:0]         be_q, be_d;
    logic [WAW-1:0]          baddr_q, baddr_d;
    logic                    wr_en_q, wr_en_d;
    logic [WAW-1:0]          addr_q, addr_d;
    logic [PACK*DATA_WIDTH-1:0] data_q, data_d;
    logic [PACK-1:0]         obe_q, obe_d;
    logic [ADDR_WIDTH:0]     cnt_q, cnt_d;
    logic                    done_q, done_d;

    logic [LW-1:0]           lane;
    logic [WAW-1:0]          waddr;
    logic                    hit;

    assign lane  = pixel_addr_i[LW-1:0];
    assign waddr = pixel_addr_i[ADDR_WIDTH-1:LW];
    assign hit   = (pixel_i >= thr_q);

    always_comb begin
        state_d = state_q;
        thr_d   = thr_q;
        buf_d   = buf_q;
        be_d    = be_q;
        baddr_d = baddr_q;
        wr_en_d = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        obe_d   = obe_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d = RUN;
                    thr_d   = threshold_i;
                    buf_d   = '0;
                    be_d    = '0;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                end
            end
            RUN: begin
                if (pixel_valid_i) begin
                    // A pixel for another word evicts the partial word first.
                    if (be_q != '0 && waddr != baddr_q) begin
                        wr_en_d = 1'b1;
                        addr_d  = baddr_q;
                        data_d  = buf_q;
                        obe_d   = be_q;
                        buf_d   = '0;
                        be_d    = '0;
                    end
                    for (int k = 0; k < PACK; k++) begin
                        if (lane == LW'(k)) begin
                            buf_d[k*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{hit}};
                            be_d[k] = 1'b1;
                        end
                    end
                    baddr_d = waddr;
                    // Cannot coincide with an eviction: one lane never fills a word.
                    if (&be_d) begin
                        wr_en_d = 1'b1;
                        addr_d  = waddr;
                        data_d  = buf_d;
                        obe_d   = be_d;
                        buf_d   = '0;
                        be_d    = '0;
                    end
                    if (hit && cnt_q != '1)
                        cnt_d = cnt_q + 1'b1;
                end
                if (src_finish_i)
                    state_d = FLUSH;
            end
            FLUSH: begin
                if (be_q != '0) begin
                    wr_en_d = 1'b1;
                    addr_d  = baddr_q;
                    data_d  = buf_q;
                    obe_d   = be_q;
                end
                buf_d   = '0;
                be_d    = '0;
                state_d = DONE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            thr_q   <= '0;
            buf_q   <= '0;
            be_q    <= '0;
            baddr_q <= '0;
            wr_en_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            obe_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            thr_q   <= thr_d;
            buf_q   <= buf_d;
            be_q    <= be_d;
            baddr_q <= baddr_d;
            wr_en_q <= wr_en_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            obe_q   <= obe_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign mem_wr_en_o = wr_en_q;
    assign mem_addr_o  = addr_q;
    assign mem_data_o  = data_q;
    assign mem_be_o    = obe_q;
    assign edge_cnt_o  = cnt_q;
    assign done_o      = done_q;
endmodule
